// File: rtl/fb_arbiter_pkg.sv
// Shared defaults and types for the frame-buffer arbiter.
// Bank-state enum is only exercised when FB_DOUBLE_BUFFER_EN is defined.
package fb_arbiter_pkg;

  localparam int FB_ADDR_W       = 20;
  localparam int FB_DATA_W       = 8;
  localparam int FB_FIFO_DEPTH   = 4;
  localparam int FB_FRAME_PIXELS = 307200;

  typedef enum logic {
    FILL,
    WAIT_SWAP
  } bank_state_e;

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_READ,
    GNT_WRITE
  } grant_e;

endpackage

// File: rtl/fb_wr_fifo.sv
// Camera write FIFO: registered storage, no push-to-pop bypass.
// Pointers carry one extra bit so full and empty can be told apart.
module fb_wr_fifo #(
  parameter int W     = 28,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;
  logic [W-1:0] store [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                 (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  // a push into a full FIFO is legal only when the head leaves this cycle
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr[PW-1:0]] <= din;
  end

  assign dout = store[rd_ptr[PW-1:0]];

endmodule

// File: rtl/fb_arbiter.sv
// Single-port frame memory arbiter: VGA reads beat camera writes.
// Define FB_DOUBLE_BUFFER_EN for a two-bank front/back frame buffer.
module fb_arbiter
  import fb_arbiter_pkg::*;
#(
  parameter int ADDR_W       = FB_ADDR_W,
  parameter int DATA_W       = FB_DATA_W,
  parameter int FIFO_DEPTH   = FB_FIFO_DEPTH,
  parameter int FRAME_PIXELS = FB_FRAME_PIXELS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cam_we,
  input  logic [ADDR_W-1:0] cam_addr,
  input  logic [DATA_W-1:0] cam_data,
  input  logic              cam_vsync,
  input  logic              vga_re,
  input  logic [ADDR_W-1:0] vga_addr,
  input  logic              vga_vsync,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_valid,
  output logic              mem_en,
  output logic              mem_we,
`ifdef FB_DOUBLE_BUFFER_EN
  output logic [ADDR_W:0]   mem_addr,
`else
  output logic [ADDR_W-1:0] mem_addr,
`endif
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wr_overflow
);

  localparam logic [ADDR_W-1:0] FRAME_LIM = ADDR_W'(FRAME_PIXELS);
  localparam int MEM_AW = $bits(mem_addr);

  logic                     cam_ok;
  logic                     vga_ok;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [ADDR_W+DATA_W-1:0] fifo_dout;
  logic [ADDR_W-1:0]        head_addr;
  logic [DATA_W-1:0]        head_data;
  logic                     ovf_set;
  logic [MEM_AW-1:0]        rd_cmd_addr;
  logic [MEM_AW-1:0]        wr_cmd_addr;
  grant_e                   grant;

  logic rd_p1;
  logic rd_p1_ok;
  logic rd_p2;
  logic rd_p2_ok;

  assign cam_ok = (cam_addr < FRAME_LIM);
  assign vga_ok = (vga_addr < FRAME_LIM);

  assign {head_addr, head_data} = fifo_dout;

  always_comb begin
    grant = GNT_IDLE;
    unique case (1'b1)
      vga_re:                 grant = GNT_READ;
      !vga_re && !fifo_empty: grant = GNT_WRITE;
      default:                grant = GNT_IDLE;
    endcase
  end

  assign fifo_pop  = (grant == GNT_WRITE);
  assign fifo_push = cam_we && cam_ok && (!fifo_full || fifo_pop);
  assign ovf_set   = cam_we && cam_ok && fifo_full && !fifo_pop;

  fb_wr_fifo #(
    .W     (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   ({cam_addr, cam_data}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef FB_DOUBLE_BUFFER_EN
  bank_state_e state_q;
  bank_state_e state_d;
  logic        front_q;
  logic        front_d;
  logic        cam_vs_q;
  logic        vga_vs_q;
  logic        cam_rise;
  logic        vga_rise;

  assign cam_rise = cam_vsync && !cam_vs_q;
  assign vga_rise = vga_vsync && !vga_vs_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FILL;
      front_q  <= 1'b0;
      cam_vs_q <= 1'b0;
      vga_vs_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      front_q  <= front_d;
      cam_vs_q <= cam_vsync;
      vga_vs_q <= vga_vsync;
    end
  end

  // a swap only happens once every buffered pixel has left for the back bank
  always_comb begin
    state_d = state_q;
    front_d = front_q;
    unique case (state_q)
      FILL: begin
        if (cam_rise) state_d = WAIT_SWAP;
      end
      WAIT_SWAP: begin
        if (vga_rise && fifo_empty) begin
          front_d = !front_q;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign rd_cmd_addr = {front_q, vga_addr};
  assign wr_cmd_addr = {!front_q, head_addr};
`else
  logic unused_vsync;

  assign unused_vsync = cam_vsync ^ vga_vsync;
  assign rd_cmd_addr  = vga_addr;
  assign wr_cmd_addr  = head_addr;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      unique case (grant)
        GNT_READ: begin
          if (vga_ok) begin
            mem_en   <= 1'b1;
            mem_addr <= rd_cmd_addr;
          end
        end
        GNT_WRITE: begin
          mem_en    <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= wr_cmd_addr;
          mem_wdata <= head_data;
        end
        default: ;
      endcase
    end
  end

  // out-of-frame reads ride the same pipe so latency stays fixed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_p1     <= 1'b0;
      rd_p1_ok  <= 1'b0;
      rd_p2     <= 1'b0;
      rd_p2_ok  <= 1'b0;
      vga_valid <= 1'b0;
      vga_data  <= '0;
    end else begin
      rd_p1     <= vga_re;
      rd_p1_ok  <= vga_ok;
      rd_p2     <= rd_p1;
      rd_p2_ok  <= rd_p1_ok;
      vga_valid <= rd_p2;
      vga_data  <= (rd_p2 && rd_p2_ok) ? mem_rdata : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_overflow <= 1'b0;
    end else if (ovf_set) begin
      wr_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: directed steps plus random traffic vs a queue model.
// Bank checks are active when built with FB_DOUBLE_BUFFER_EN.
module tb_fb_arbiter;

  localparam int AW    = 20;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int FP    = 307200;
`ifdef FB_DOUBLE_BUFFER_EN
  localparam int MAW = AW + 1;
`else
  localparam int MAW = AW;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           cam_we = 1'b0;
  logic [AW-1:0]  cam_addr = '0;
  logic [DW-1:0]  cam_data = '0;
  logic           cam_vsync = 1'b0;
  logic           vga_re = 1'b0;
  logic [AW-1:0]  vga_addr = '0;
  logic           vga_vsync = 1'b0;
  logic [DW-1:0]  vga_data;
  logic           vga_valid;
  logic           mem_en;
  logic           mem_we;
  logic [MAW-1:0] mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic [DW-1:0]  mem_rdata = '0;
  logic           wr_overflow;

  int npass  = 0;
  int ntotal = 0;

  fb_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .FIFO_DEPTH   (DEPTH),
    .FRAME_PIXELS (FP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cam_we      (cam_we),
    .cam_addr    (cam_addr),
    .cam_data    (cam_data),
    .cam_vsync   (cam_vsync),
    .vga_re      (vga_re),
    .vga_addr    (vga_addr),
    .vga_vsync   (vga_vsync),
    .vga_data    (vga_data),
    .vga_valid   (vga_valid),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .wr_overflow (wr_overflow)
  );

  always #10 clk = ~clk;

  function automatic logic [DW-1:0] init_px(input logic [MAW-1:0] a);
    return DW'(a) ^ 8'h3C;
  endfunction

  // external synchronous single-port memory
  logic [DW-1:0] bmem [logic [MAW-1:0]];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bmem[mem_addr] = mem_wdata;
      else mem_rdata <= bmem.exists(mem_addr) ? bmem[mem_addr] : init_px(mem_addr);
    end
  end

  // reference model state
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } px_t;

  px_t            q[$];
  logic [DW-1:0]  rmem [logic [MAW-1:0]];
  logic           e_en;
  logic           e_we;
  logic [MAW-1:0] e_addr;
  logic [DW-1:0]  e_wd;
  logic           e_ovf;
  logic           pv [3];
  logic [DW-1:0]  pd [3];
  logic           front;
  logic           armed;
  logic           cam_prev;
  logic           vga_prev;

  function automatic logic [MAW-1:0] full_addr(input logic bank, input logic [AW-1:0] a);
`ifdef FB_DOUBLE_BUFFER_EN
    return {bank, a};
`else
    return bank ? a : a;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0; e_ovf = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end
    front = 1'b0; armed = 1'b0; cam_prev = 1'b0; vga_prev = 1'b0;
  endtask

  task automatic cycle(input logic we, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                       input logic re, input logic [AW-1:0] va,
                       input logic cvs = 1'b0, input logic vvs = 1'b0);
    logic           was_empty;
    logic           pop;
    logic [MAW-1:0] ra;
    px_t            px;
    cam_we = we; cam_addr = ca; cam_data = cd;
    vga_re = re; vga_addr = va;
    cam_vsync = cvs; vga_vsync = vvs;
    was_empty = (q.size() == 0);
    pop = !re && !was_empty;
    e_en = 1'b0;
    e_we = 1'b0;
    ra = full_addr(front, va);
    pv[2] = pv[1]; pd[2] = pd[1];
    pv[1] = pv[0]; pd[1] = pd[0];
    pv[0] = re;
    pd[0] = '0;
    if (re && (int'(va) < FP)) begin
      e_en = 1'b1;
      e_addr = ra;
      pd[0] = rmem.exists(ra) ? rmem[ra] : init_px(ra);
    end
    if (pop) begin
      px = q.pop_front();
      e_en = 1'b1;
      e_we = 1'b1;
      e_addr = full_addr(!front, px.a);
      e_wd = px.d;
      rmem[e_addr] = px.d;
    end
    if (we && (int'(ca) < FP)) begin
      if (q.size() < DEPTH) q.push_back('{a: ca, d: cd});
      else e_ovf = 1'b1;
    end
`ifdef FB_DOUBLE_BUFFER_EN
    if (!armed) begin
      if (cvs && !cam_prev) armed = 1'b1;
    end else if (vvs && !vga_prev && was_empty) begin
      front = !front;
      armed = 1'b0;
    end
`endif
    cam_prev = cvs;
    vga_prev = vvs;
    @(posedge clk); #1;
    chk("mem_en", 32'(mem_en), 32'(e_en));
    if (e_en) begin
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      if (e_we) chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
    end
    chk("vga_valid", 32'(vga_valid), 32'(pv[2]));
    if (pv[2]) chk("vga_data", 32'(vga_data), 32'(pd[2]));
    chk("wr_overflow", 32'(wr_overflow), 32'(e_ovf));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic check_zero_outputs(input string pfx);
    chk({pfx, "_mem_en"}, 32'(mem_en), 32'h0);
    chk({pfx, "_mem_we"}, 32'(mem_we), 32'h0);
    chk({pfx, "_mem_addr"}, 32'(mem_addr), 32'h0);
    chk({pfx, "_mem_wdata"}, 32'(mem_wdata), 32'h0);
    chk({pfx, "_vga_valid"}, 32'(vga_valid), 32'h0);
    chk({pfx, "_vga_data"}, 32'(vga_data), 32'h0);
    chk({pfx, "_wr_overflow"}, 32'(wr_overflow), 32'h0);
  endtask

  initial begin
    logic          rb;
    logic          cv;
    logic          vv;
    logic [AW-1:0] ca;
    logic [AW-1:0] va;
    model_reset();
    #25;
    check_zero_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // single write, then read it back, then an out-of-frame read
    cycle(1'b1, AW'(5), 8'hA5, 1'b0, '0);
    idle(3);
    cycle(1'b0, '0, '0, 1'b1, AW'(5));
    idle(4);
    cycle(1'b0, '0, '0, 1'b1, AW'(FP));
    idle(4);
    cycle(1'b0, '0, '0, 1'b1, AW'(FP - 1));
    idle(4);

    // reads hold the port for 10 cycles while 6 pixels arrive
    for (int i = 0; i < 10; i++)
      cycle(i < 6, AW'(16 + i), DW'(8'h10 + i), 1'b1, AW'(32 + i));
    idle(8);
    chk("overflow_after_burst", 32'(wr_overflow), 32'h1);

    // out-of-frame camera pixel is dropped silently
    cycle(1'b1, AW'(FP + 3), 8'h77, 1'b0, '0);
    idle(3);

    // full FIFO accepts a push when the head pops in the same cycle
    for (int i = 0; i < 4; i++)
      cycle(1'b1, AW'(40 + i), DW'(8'h40 + i), 1'b1, AW'(i));
    for (int i = 0; i < 3; i++)
      cycle(1'b1, AW'(50 + i), DW'(8'h50 + i), 1'b0, '0);
    idle(8);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b1, AW'(50 + i));
    idle(4);

    // random traffic
    rb = 1'b0; cv = 1'b0; vv = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 4) == 0) rb = !rb;
      if ($urandom_range(0, 19) == 0) cv = !cv;
      if ($urandom_range(0, 13) == 0) vv = !vv;
      ca = ($urandom_range(0, 9) == 0) ? AW'(FP + $urandom_range(0, 100))
                                       : AW'($urandom_range(0, 31));
      va = ($urandom_range(0, 9) == 0) ? AW'(FP + $urandom_range(0, 3))
                                       : AW'($urandom_range(0, 31));
      cycle($urandom_range(0, 9) < 6, ca, DW'($urandom), rb, va, cv, vv);
    end
    idle(8);

`ifdef FB_DOUBLE_BUFFER_EN
    // bring the model and DUT to a known bank phase, then swap once
    cycle(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
    idle(2);
    for (int i = 0; i < 4; i++)
      cycle(1'b1, AW'(60 + i), DW'(8'hC0 + i), 1'b0, '0);
    idle(4);
    cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1);
    idle(1);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b1, AW'(60 + i));
    idle(4);
    // coincident edges only arm the swap
    cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1);
    cycle(1'b0, '0, '0, 1'b1, AW'(1), 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, AW'(2), 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b1, AW'(3), 1'b0, 1'b0);
    idle(4);
`endif

    // asynchronous reset with three pixels parked in the FIFO
    for (int i = 0; i < 3; i++)
      cycle(1'b1, AW'(70 + i), DW'(8'h70 + i), 1'b1, AW'(i));
    reset = 1'b1;
    #1;
    check_zero_outputs("async_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    idle(6);
    chk("post_reset_overflow", 32'(wr_overflow), 32'h0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameters, one per line: ADDR_W 20, pixel address width; DATA_W 8, pixel width; FIFO_DEPTH 4, camera write FIFO entries (power of 2); FRAME_PIXELS 307200, valid pixels per frame (640x480).
REQ-002 clk  in  1  single system clock (CLOCK_50 domain).
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 cam_we  in  1  camera pixel write strobe, one pixel per asserted cycle.
REQ-005 cam_addr  in  ADDR_W  camera pixel address.
REQ-006 cam_data  in  DATA_W  camera pixel value.
REQ-007 cam_vsync  in  1  camera frame marker, level; rising edge = frame complete.
REQ-008 vga_re  in  1  VGA read request, one pixel per asserted cycle.
REQ-009 vga_addr  in  ADDR_W  VGA pixel address.
REQ-010 vga_vsync  in  1  VGA frame marker, level; rising edge = display frame start.
REQ-011 vga_data  out  DATA_W  read pixel; vga_valid  out  1  vga_data qualifier.
REQ-012 mem_en, mem_we  out  1 each  memory port enable / write select.
REQ-013 mem_addr  out  ADDR_W (+1 with double buffering)  memory address; mem_wdata  out  DATA_W; mem_rdata  in  DATA_W, synchronous, valid the cycle after a read command.
REQ-014 wr_overflow  out  1  sticky camera-pixel-lost flag.

Function
REQ-015 Block SHALL share one single-port frame memory between camera writes and VGA reads; VGA reads have strict priority.
REQ-016 Memory command outputs SHALL be registered; at most one command per cycle.
REQ-017 Per-cycle grant: vga_re=1 -> READ; else FIFO non-empty -> WRITE (pop head); else IDLE (mem_en=0, mem_we=0).
REQ-018 Read latency SHALL be exactly 3 cycles: vga_re in cycle N -> mem command in N+1 -> mem_rdata in N+2 -> vga_data/vga_valid registered in N+3, vga_valid high for one cycle per request.
REQ-019 vga_addr >= FRAME_PIXELS SHALL issue no memory command and return vga_data=0 with vga_valid at the same 3-cycle latency.
REQ-020 cam_we with cam_addr >= FRAME_PIXELS SHALL be discarded, not pushed, no flag.
REQ-021 Write FIFO SHALL hold {addr,data}, FIFO_DEPTH entries, in-order.
REQ-022 cam_we when FIFO full and no pop in that cycle SHALL drop the pixel and set wr_overflow; push with simultaneous pop when full SHALL be accepted.
REQ-023 Push and pop on empty FIFO SHALL not bypass: pixel is written no earlier than the following cycle.
REQ-024 wr_overflow SHALL stay 1 until reset.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH; full/empty distinguished by one extra pointer bit.

Reset
REQ-026 On reset: FIFO empty, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, vga_data=0, vga_valid=0, wr_overflow=0, bank state FILL, front bank 0; in-flight reads discarded.
REQ-027 Reset asserted mid-operation SHALL take effect immediately, asynchronously; no pending pixel written after release.

Configuration
REQ-028 Macro FB_DOUBLE_BUFFER_EN SHALL select double buffering.
REQ-029 Without it: single bank, mem_addr width ADDR_W, cam_vsync/vga_vsync ignored.
REQ-030 With it: mem_addr width ADDR_W+1, MSB = bank; writes use back bank (~front), reads use front bank.
REQ-031 With it, bank FSM: FILL -> (cam_vsync rising) -> WAIT_SWAP; WAIT_SWAP -> (vga_vsync rising AND FIFO empty) -> flip front, FILL; camera writes in WAIT_SWAP still go to back bank.
REQ-032 Simultaneous cam_vsync and vga_vsync rising edges in FILL SHALL only enter WAIT_SWAP; swap waits for the next vga_vsync edge.

Structure
REQ-033 Shared package SHALL hold ADDR_W, DATA_W, FRAME_PIXELS defaults and the bank-state enum {FILL, WAIT_SWAP}.
REQ-034 Write FIFO SHALL be a sub-module fb_wr_fifo; arbitration, read pipeline and bank FSM in fb_arbiter.

Verification
REQ-035 Single write addr 5 data 0xA5, no reads -> mem_en=1, mem_we=1, mem_addr=5, mem_wdata=0xA5 two cycles after cam_we.
REQ-036 vga_re addr 5 in cycle N with mem returning 0xA5 -> vga_data=0xA5, vga_valid=1 in N+3 only.
REQ-037 vga_re held 10 cycles while 6 camera pixels arrive -> 4 buffered, 2 dropped, wr_overflow=1; after vga_re drops, 4 writes in order.
REQ-038 vga_addr 307200 -> no mem_en, vga_data=0, vga_valid=1 at N+3.
REQ-039 FB_DOUBLE_BUFFER_EN: write frame, cam_vsync edge, vga_vsync edge with FIFO empty -> front flips 0->1, reads use MSB=1, writes MSB=0.
REQ-040 Reset asserted with 3 FIFO entries -> outputs zero immediately, no writes after release, wr_overflow=0.
